// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON-128 control FSM.
// The WAIT_AD/AD states exist only when ASCON_AD_EN is defined.
package ascon_pkg;

    localparam logic [3:0] ROUND_PA_FIRST = 4'd0;
    localparam logic [3:0] ROUND_PB_FIRST = 4'd6;
    localparam logic [3:0] ROUND_LAST     = 4'd11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CONF_INIT,
        ST_INIT,
`ifdef ASCON_AD_EN
        ST_WAIT_AD,
        ST_AD,
`endif
        ST_WAIT_PT,
        ST_PT,
        ST_WAIT_FINAL,
        ST_FINAL,
        ST_END
    } state_t;

endpackage

// File: rtl/ascon_ctrl_fsm.sv
// ASCON-128 encryption sequencer: drives the sibling round counter and the
// state-register / XOR enables for init, one AD block (ASCON_AD_EN),
// NB_BLOCKS plaintext blocks and tag finalization.
// Build option: define ASCON_AD_EN to include the associated-data phase.
module ascon_ctrl_fsm
    import ascon_pkg::*;
#(
    parameter int NB_BLOCKS = 4
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    input  logic [3:0] round_i,
    output logic       en_cpt_o,
    output logic       init_a_o,
    output logic       init_b_o,
    output logic       en_reg_state_o,
    output logic       input_mode_o,
    output logic       en_xor_data_o,
    output logic       en_xor_key_begin_o,
    output logic       en_xor_key_end_o,
    output logic       en_xor_lsb_o,
    output logic       data_ready_o,
    output logic       cipher_valid_o,
    output logic       tag_valid_o,
    output logic       done_o
);

    localparam int CNT_W = $clog2(NB_BLOCKS);

    // Count value seen on the last p^b plaintext block; the block after it
    // is absorbed during the p^a finalization instead.
    localparam logic [CNT_W-1:0] LAST_PT = CNT_W'(NB_BLOCKS - 2);

    state_t           state;
    logic [CNT_W-1:0] blk_cnt;

    logic round_last;
    assign round_last = (round_i == ROUND_LAST);

    // State and block-count sequencing.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!resetb_i) begin
            state   <= ST_IDLE;
            blk_cnt <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start_i) state <= ST_CONF_INIT;
                end
                ST_CONF_INIT: state <= ST_INIT;
                ST_INIT: begin
`ifdef ASCON_AD_EN
                    if (round_last) state <= ST_WAIT_AD;
`else
                    if (round_last) state <= ST_WAIT_PT;
`endif
                end
`ifdef ASCON_AD_EN
                ST_WAIT_AD: begin
                    if (data_valid_i) state <= ST_AD;
                end
                ST_AD: begin
                    if (round_last) state <= ST_WAIT_PT;
                end
`endif
                ST_WAIT_PT: begin
                    if (data_valid_i) state <= ST_PT;
                end
                ST_PT: begin
                    if (round_last) begin
                        blk_cnt <= blk_cnt + 1'b1;
                        state   <= (blk_cnt == LAST_PT) ? ST_WAIT_FINAL : ST_WAIT_PT;
                    end
                end
                ST_WAIT_FINAL: begin
                    if (data_valid_i) state <= ST_FINAL;
                end
                ST_FINAL: begin
                    if (round_last) state <= ST_END;
                end
                ST_END: begin
                    state   <= ST_IDLE;
                    blk_cnt <= '0;
                end
                default: begin
                    state   <= ST_IDLE;
                    blk_cnt <= '0;
                end
            endcase
        end
    end

    // Output decode from the current state and round index.
    always_comb begin
        // NOTE: every output is defaulted first so no path through the case
        // leaves one unassigned and infers a latch.
        en_cpt_o           = 1'b0;
        init_a_o           = 1'b0;
        init_b_o           = 1'b0;
        en_reg_state_o     = 1'b0;
        input_mode_o       = 1'b0;
        en_xor_data_o      = 1'b0;
        en_xor_key_begin_o = 1'b0;
        en_xor_key_end_o   = 1'b0;
        en_xor_lsb_o       = 1'b0;
        data_ready_o       = 1'b0;
        cipher_valid_o     = 1'b0;
        tag_valid_o        = 1'b0;
        done_o             = 1'b0;
        unique case (state)
            ST_CONF_INIT: begin
                en_cpt_o       = 1'b1;
                init_a_o       = 1'b1;
                input_mode_o   = 1'b1;
                en_reg_state_o = 1'b1;
            end
            ST_INIT: begin
                en_cpt_o       = 1'b1;
                en_reg_state_o = 1'b1;
                if (round_last) begin
                    en_xor_key_end_o = 1'b1;
                    init_b_o         = 1'b1;
`ifndef ASCON_AD_EN
                    // No AD block: the domain separation bit follows init directly.
                    en_xor_lsb_o     = 1'b1;
`endif
                end
            end
`ifdef ASCON_AD_EN
            ST_AD: begin
                en_cpt_o       = 1'b1;
                en_reg_state_o = 1'b1;
                en_xor_data_o  = (round_i == ROUND_PB_FIRST);
                if (round_last) begin
                    en_xor_lsb_o = 1'b1;
                    init_b_o     = 1'b1;
                end
            end
            ST_WAIT_AD: data_ready_o = 1'b1;
`endif
            ST_WAIT_PT:    data_ready_o = 1'b1;
            ST_WAIT_FINAL: data_ready_o = 1'b1;
            ST_PT: begin
                en_cpt_o       = 1'b1;
                en_reg_state_o = 1'b1;
                en_xor_data_o  = (round_i == ROUND_PB_FIRST);
                cipher_valid_o = (round_i == ROUND_PB_FIRST);
                if (round_last) begin
                    // Reload 0 before the p^a finalization, 6 for another p^b block.
                    if (blk_cnt == LAST_PT) init_a_o = 1'b1;
                    else                    init_b_o = 1'b1;
                end
            end
            ST_FINAL: begin
                en_cpt_o       = 1'b1;
                en_reg_state_o = 1'b1;
                if (round_i == ROUND_PA_FIRST) begin
                    en_xor_data_o      = 1'b1;
                    en_xor_key_begin_o = 1'b1;
                    cipher_valid_o     = 1'b1;
                end
                en_xor_key_end_o = round_last;
            end
            ST_END: begin
                tag_valid_o = 1'b1;
                done_o      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Self-checking bench for ascon_ctrl_fsm; models the sibling round counter.
module tb_ascon_ctrl_fsm;

    localparam int NB = 4;
`ifdef ASCON_AD_EN
    localparam bit AD_EN   = 1'b1;
    localparam int LATENCY = 55;
`else
    localparam bit AD_EN   = 1'b0;
    localparam int LATENCY = 48;
`endif

    // Packed output vector bit positions.
    localparam logic [12:0] O_CPT   = 13'h1000;
    localparam logic [12:0] O_IA    = 13'h0800;
    localparam logic [12:0] O_IB    = 13'h0400;
    localparam logic [12:0] O_REG   = 13'h0200;
    localparam logic [12:0] O_MODE  = 13'h0100;
    localparam logic [12:0] O_XDATA = 13'h0080;
    localparam logic [12:0] O_KBEG  = 13'h0040;
    localparam logic [12:0] O_KEND  = 13'h0020;
    localparam logic [12:0] O_LSB   = 13'h0010;
    localparam logic [12:0] O_READY = 13'h0008;
    localparam logic [12:0] O_CV    = 13'h0004;
    localparam logic [12:0] O_TAG   = 13'h0002;
    localparam logic [12:0] O_DONE  = 13'h0001;

    logic       clock_i;
    logic       resetb_i;
    logic       start_i;
    logic       data_valid_i;
    logic [3:0] round_i;
    logic       en_cpt_o, init_a_o, init_b_o, en_reg_state_o, input_mode_o;
    logic       en_xor_data_o, en_xor_key_begin_o, en_xor_key_end_o, en_xor_lsb_o;
    logic       data_ready_o, cipher_valid_o, tag_valid_o, done_o;
    logic [12:0] outs;

    ascon_ctrl_fsm #(.NB_BLOCKS(NB)) dut (
        .clock_i            (clock_i),
        .resetb_i           (resetb_i),
        .start_i            (start_i),
        .data_valid_i       (data_valid_i),
        .round_i            (round_i),
        .en_cpt_o           (en_cpt_o),
        .init_a_o           (init_a_o),
        .init_b_o           (init_b_o),
        .en_reg_state_o     (en_reg_state_o),
        .input_mode_o       (input_mode_o),
        .en_xor_data_o      (en_xor_data_o),
        .en_xor_key_begin_o (en_xor_key_begin_o),
        .en_xor_key_end_o   (en_xor_key_end_o),
        .en_xor_lsb_o       (en_xor_lsb_o),
        .data_ready_o       (data_ready_o),
        .cipher_valid_o     (cipher_valid_o),
        .tag_valid_o        (tag_valid_o),
        .done_o             (done_o)
    );

    assign outs = {en_cpt_o, init_a_o, init_b_o, en_reg_state_o, input_mode_o,
                   en_xor_data_o, en_xor_key_begin_o, en_xor_key_end_o, en_xor_lsb_o,
                   data_ready_o, cipher_valid_o, tag_valid_o, done_o};

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    // Sibling 4-bit round counter: load 0, load 6, or count.
    always @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i)     round_i <= 4'd0;
        else if (init_a_o) round_i <= 4'd0;
        else if (init_b_o) round_i <= 4'd6;
        else if (en_cpt_o) round_i <= round_i + 4'd1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    typedef struct {
        int          cyc;      // cycle index, start-sampling edge = 0 (AD build timeline)
        int          mode;     // 0 both builds, 1 AD build only, 2 no-AD build only
        bit          has_rnd;
        logic [3:0]  rnd;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];
    logic [3:0]  exp_q[$];
    logic [12:0] trace_outs [0:79];
    logic [3:0]  trace_rnd  [0:79];

    task automatic add_vec(input int cyc, input int mode, input bit has_rnd,
                           input logic [3:0] rnd, input logic [12:0] exp);
        vec_t v;
        v.cyc = cyc; v.mode = mode; v.has_rnd = has_rnd; v.rnd = rnd; v.exp = exp;
        vecs.push_back(v);
    endtask

    // One message with data_valid held high; start optionally re-pulsed at pulse_cyc.
    task automatic run_held(input int pulse_cyc, output int done_cyc);
        done_cyc = -1;
        @(negedge clock_i);
        start_i      = 1'b1;
        data_valid_i = 1'b1;
        for (int b = 0; b < NB - 1; b++) exp_q.push_back(4'd6);
        exp_q.push_back(4'd0);
        @(posedge clock_i);
        for (int n = 1; n <= 70; n++) begin
            @(negedge clock_i);
            trace_outs[n] = outs;
            trace_rnd[n]  = round_i;
            start_i = (n == pulse_cyc);
            if (cipher_valid_o) begin
                if (exp_q.size() == 0) check("cipher_unexpected", 32'(cipher_valid_o), 32'd0);
                else                   check("cipher_round", 32'(round_i), 32'(exp_q.pop_front()));
            end
            if (done_o && done_cyc < 0) done_cyc = n;
        end
        data_valid_i = 1'b0;
        check("scoreboard_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock_i);
            if (data_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock_i);
            if (done_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cyc;
        int c;
        int cpt_cnt;
        bit ok;

        add_vec( 1, 0, 1'b0, 4'd0,  O_CPT | O_IA | O_MODE | O_REG);
        add_vec( 2, 0, 1'b1, 4'd0,  O_CPT | O_REG);
        add_vec( 8, 0, 1'b1, 4'd6,  O_CPT | O_REG);
        add_vec(13, 1, 1'b1, 4'd11, O_CPT | O_REG | O_KEND | O_IB);
        add_vec(13, 2, 1'b1, 4'd11, O_CPT | O_REG | O_KEND | O_LSB | O_IB);
        add_vec(14, 1, 1'b1, 4'd6,  O_READY);
        add_vec(15, 1, 1'b1, 4'd6,  O_CPT | O_REG | O_XDATA);
        add_vec(16, 1, 1'b1, 4'd7,  O_CPT | O_REG);
        add_vec(20, 1, 1'b1, 4'd11, O_CPT | O_REG | O_LSB | O_IB);
        add_vec(21, 0, 1'b1, 4'd6,  O_READY);
        add_vec(22, 0, 1'b1, 4'd6,  O_CPT | O_REG | O_XDATA | O_CV);
        add_vec(23, 0, 1'b1, 4'd7,  O_CPT | O_REG);
        add_vec(27, 0, 1'b1, 4'd11, O_CPT | O_REG | O_IB);
        add_vec(28, 0, 1'b1, 4'd6,  O_READY);
        add_vec(34, 0, 1'b1, 4'd11, O_CPT | O_REG | O_IB);
        add_vec(41, 0, 1'b1, 4'd11, O_CPT | O_REG | O_IA);
        add_vec(42, 0, 1'b1, 4'd0,  O_READY);
        add_vec(43, 0, 1'b1, 4'd0,  O_CPT | O_REG | O_XDATA | O_KBEG | O_CV);
        add_vec(44, 0, 1'b1, 4'd1,  O_CPT | O_REG);
        add_vec(54, 0, 1'b1, 4'd11, O_CPT | O_REG | O_KEND);
        add_vec(55, 0, 1'b1, 4'd12, O_TAG | O_DONE);
        add_vec(56, 0, 1'b1, 4'd12, 13'h0000);

        // Reset state.
        start_i      = 1'b0;
        data_valid_i = 1'b0;
        resetb_i     = 1'b1;
        #1 resetb_i  = 1'b0;
        #1 check("reset_outs", 32'(outs), 32'd0);
        repeat (3) @(negedge clock_i);
        resetb_i = 1'b1;
        @(negedge clock_i);
        check("idle_outs", 32'(outs), 32'd0);

        // Full message with data_valid held high, compared against the table.
        run_held(0, done_cyc);
        check("latency_held", done_cyc, LATENCY);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].mode == 1 && !AD_EN) continue;
            if (vecs[i].mode == 2 && AD_EN) continue;
            c = (!AD_EN && vecs[i].cyc >= 14) ? vecs[i].cyc - 7 : vecs[i].cyc;
            check($sformatf("vec%0d_cyc%0d_outs", i, c), 32'(trace_outs[c]), 32'(vecs[i].exp));
            if (vecs[i].has_rnd)
                check($sformatf("vec%0d_cyc%0d_round", i, c), 32'(trace_rnd[c]), 32'(vecs[i].rnd));
        end
        cpt_cnt = 0;
        for (int n = 2; n <= 14; n++) cpt_cnt += int'(trace_outs[n][12]);
        check("init_cpt_cycles", cpt_cnt, 12);

        // data_valid withheld for 10 cycles in WAIT_PT.
        @(negedge clock_i);
        start_i = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0;
        wait_ready(ok);
        check("reach_first_wait", 32'(ok), 32'd1);
        if (AD_EN) begin
            data_valid_i = 1'b1;
            @(negedge clock_i);
            data_valid_i = 1'b0;
            wait_ready(ok);
            check("reach_wait_pt", 32'(ok), 32'd1);
        end
        for (int k = 0; k < 10; k++) begin
            check($sformatf("withheld_%0d", k), 32'({outs, round_i}), 32'({O_READY, 4'd6}));
            @(negedge clock_i);
        end
        data_valid_i = 1'b1;
        wait_done(ok);
        check("withheld_done", 32'(ok), 32'd1);
        data_valid_i = 1'b0;
        @(negedge clock_i);
        check("withheld_back_idle", 32'(outs), 32'd0);

        // start_i pulsed during the AD phase (PT1 without AD): latency unchanged.
        run_held(16, done_cyc);
        check("latency_start_pulse", done_cyc, LATENCY);

        // Reset asserted mid-INIT at round 5.
        @(negedge clock_i);
        start_i      = 1'b1;
        data_valid_i = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock_i);
            if (en_cpt_o && round_i == 4'd5) begin
                ok = 1'b1;
                break;
            end
        end
        check("reach_init_r5", 32'(ok), 32'd1);
        #2 resetb_i = 1'b0;
        #1 check("async_reset_mid_init", 32'(outs), 32'd0);
        @(negedge clock_i);
        resetb_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock_i);
            check($sformatf("post_reset_idle_%0d", k), 32'(outs), 32'd0);
        end
        run_held(0, done_cyc);
        check("latency_after_reset", done_cyc, LATENCY);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ascon_ctrl_fsm.md
# ascon_ctrl_fsm

Control state machine that sequences the ASCON-128 encryption permutation. It drives the sibling 4-bit round counter through `en_cpt_o`, `init_a_o` and `init_b_o`, and reads back `round_i`. It also generates every enable and select for the state register and the XOR stages. It sits in the top level between the external data interface and the permutation datapath, and processes one associated-data block, `NB_BLOCKS` plaintext blocks and the tag finalization.

## Interface
- `NB_BLOCKS`, default 4: plaintext blocks per message; must be ≥ 2.
- `clock_i`  in  1  clock, rising edge.
- `resetb_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  start a message; sampled in IDLE only.
- `data_valid_i`  in  1  input block present; sampled in WAIT_* states only.
- `round_i`  in  4  current round index from the round counter.
- `en_cpt_o`, `init_a_o`, `init_b_o`  out  1 each  round counter controls: enable, load 0, load 6.
- `en_reg_state_o`  out  1  state register load.
- `input_mode_o`  out  1  1 selects IV‖K‖N into the state, 0 selects round feedback.
- `en_xor_data_o`  out  1  XOR input block into x0 before the round.
- `en_xor_key_begin_o`  out  1  XOR 0‖K into x3,x4 before the round.
- `en_xor_key_end_o`  out  1  XOR 0*‖K into x3,x4 after the round.
- `en_xor_lsb_o`  out  1  XOR domain separation bit 1 into the x4 LSB after the round.
- `data_ready_o`  out  1  controller is waiting for a block.
- `cipher_valid_o`  out  1  ciphertext block valid this cycle.
- `tag_valid_o`, `done_o`  out  1 each  tag valid / message finished.

## Operation
- Every output defaults to 0. Under reset: all outputs 0, FSM in IDLE, block count 0.
- IDLE: on `start_i`=1, go to CONF_INIT.
- CONF_INIT, one cycle: `en_cpt_o`, `init_a_o`, `input_mode_o` and `en_reg_state_o` all 1. Go to INIT.
- INIT: `en_cpt_o` and `en_reg_state_o` are 1.
  - At `round_i`=11 also assert `en_xor_key_end_o` and `init_b_o`, then go to WAIT_AD.
- WAIT_AD, WAIT_PT, WAIT_FINAL: all enables 0 and the counter holds. `data_ready_o`=1. On `data_valid_i`=1, go to AD, PT or FINAL respectively.
- AD: `en_cpt_o` and `en_reg_state_o` are 1; `en_xor_data_o` is 1 when `round_i`=6.
  - At `round_i`=11 assert `en_xor_lsb_o` and `init_b_o`, then go to WAIT_PT.
- PT: same as AD, plus `cipher_valid_o`=1 when `round_i`=6.
  - At `round_i`=11, increment the block count.
  - If the count was `NB_BLOCKS`-2, assert `init_a_o` and go to WAIT_FINAL; otherwise assert `init_b_o` and go to WAIT_PT.
- FINAL: `en_cpt_o` and `en_reg_state_o` are 1.
  - At `round_i`=0 also assert `en_xor_data_o`, `en_xor_key_begin_o` and `cipher_valid_o`.
  - At `round_i`=11 assert `en_xor_key_end_o` and go to END.
- END, one cycle: `tag_valid_o`=1 and `done_o`=1, then go to IDLE with the block count cleared.
- The block count is `$clog2(NB_BLOCKS)` bits wide, unsigned, and never wraps within a message.
- `start_i` outside IDLE is ignored. `data_valid_i` outside WAIT_* is ignored.
- Reset mid-message aborts immediately to IDLE; no partial outputs are produced.

## Timing
- All state transitions occur on the `clock_i` rising edge. Outputs are decoded combinationally from the state and `round_i`.
- Each WAIT_* state lasts at least 1 cycle, even when `data_valid_i` is held high.
- p^a phases last 12 cycles and p^b phases last 6 cycles.
- With `NB_BLOCKS`=4, AD enabled, and `data_valid_i` held 1, END is reached 55 cycles after the `start_i` sampling edge.
- The counter is never enabled in IDLE, WAIT_* or END.

## Configuration
- Macro: `ASCON_AD_EN`.
- Defined: the WAIT_AD and AD states exist, as described above.
- Undefined: those states are not compiled. INIT at `round_i`=11 asserts `en_xor_key_end_o`, `en_xor_lsb_o` and `init_b_o` together, then goes to WAIT_PT.
  - Total latency drops by 7 cycles, to 48.

## Structure
- Package `ascon_pkg` holds:
  - the FSM state enum typedef;
  - constants `ROUND_PA_FIRST`=4'd0, `ROUND_PB_FIRST`=4'd6 and `ROUND_LAST`=4'd11.
- No sub-module: the block count is inline. The round counter remains a sibling instance in the top level.

## Test plan
- Reset asserted mid-INIT (`round_i`=5): all outputs go to 0 asynchronously. After release, the FSM stays in IDLE until `start_i`.
- `start_i` pulse with `data_valid_i`=1: `init_a_o` is 1 exactly 1 cycle after the edge, then `en_cpt_o` is high for 12 cycles, and `en_xor_key_end_o` coincides with `round_i`=11.
- `data_valid_i` held 1, `NB_BLOCKS`=4: `cipher_valid_o` pulses 4 times (3 at `round_i`=6, 1 at `round_i`=0). `done_o` is high at cycle 55.
- `data_valid_i` withheld 10 cycles in WAIT_PT: `data_ready_o` stays 1, `round_i` holds at 6, and the counter is not enabled.
- `start_i` pulsed during AD: no effect, and the total latency is unchanged.
- Build without `ASCON_AD_EN`: `en_xor_lsb_o` and `en_xor_key_end_o` are asserted in the same cycle, and `done_o` is high at cycle 48.
